dual_issue_hazard_ctrl: RTL

// - Issue/hazard controller for the two-slot ID->EX boundary of the superscalar core.
// - Each cycle, decides per slot whether the decoded instruction is latched into its ID/EX

---
 rtl/core_pkg.sv | 14 +
 rtl/hazard_cmp.sv | 17 +
 rtl/dual_issue_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the dual-issue ID->EX hazard control.
package core_pkg;

    // Controller states: normal issue, counting load-use bubbles, second half of a split pair.
    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        LU_STALL = 2'd1,
        SPLIT    = 2'd2
    } state_t;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_cmp.sv
// Matches one source operand against one in-flight destination.
// Register 0 is hard-wired, so it never produces a hit.
module hazard_cmp
    import core_pkg::*;
(
    input  logic                 src_vld,
    input  logic                 src_use,
    input  logic [REG_IDX_W-1:0] src_idx,
    input  logic                 dst_en,
    input  logic [REG_IDX_W-1:0] dst_idx,
    output logic                 hit
);

    assign hit = src_vld && src_use && dst_en &&
                 (dst_idx != ZERO_REG) && (src_idx == dst_idx);

endmodule

// File: rtl/dual_issue_hazard_ctrl.sv
// Issue/hazard controller for the two-slot ID->EX boundary.
// Decides per slot whether to latch or bubble, holds IF/ID on stalls,
// and reports HasStalled and a saturating stall-cycle count.
module dual_issue_hazard_ctrl
    import core_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 vld0,
    input  logic                 vld1,
    input  logic [REG_IDX_W-1:0] rs0,
    input  logic [REG_IDX_W-1:0] rt0,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rt1,
    input  logic                 use_rs0,
    input  logic                 use_rt0,
    input  logic                 use_rs1,
    input  logic                 use_rt1,
    input  logic [REG_IDX_W-1:0] wr0,
    input  logic [REG_IDX_W-1:0] wr1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic                 mrd0,
    input  logic                 mrd1,
    input  logic                 mwr0,
    input  logic                 mwr1,
    input  logic                 ex_mrd0,
    input  logic                 ex_mrd1,
    input  logic [REG_IDX_W-1:0] ex_wr0,
    input  logic [REG_IDX_W-1:0] ex_wr1,
    output logic                 issue0,
    output logic                 issue1,
    output logic                 hold_ifid,
    output logic                 has_stalled0,
    output logic                 has_stalled1,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam logic [1:0] BUB_INIT = 2'(LU_BUBBLES - 1);

    state_t     state, state_nx;
    logic [1:0] bub_cnt, bub_cnt_nx;
    logic       sticky0, sticky1;

    // Source operands flattened: 0=rs0, 1=rt0, 2=rs1, 3=rt1.
    logic [3:0]                src_vld, src_use;
    logic [3:0][REG_IDX_W-1:0] src_idx;
    logic [1:0]                ex_mrd;
    logic [1:0][REG_IDX_W-1:0] ex_wr;
    logic [7:0]                lu_hit;
    logic [1:0]                raw_hit;
    logic                      lu0, lu1, waw, mem_conf, pair;

    assign src_vld = {vld1, vld1, vld0, vld0};
    assign src_use = {use_rt1, use_rs1, use_rt0, use_rs0};
    assign src_idx = {rt1, rs1, rt0, rs0};
    assign ex_mrd  = {ex_mrd1, ex_mrd0};
    assign ex_wr   = {ex_wr1, ex_wr0};

    // Load-use: every ID source against every EX-slot load destination.
    for (genvar e = 0; e < 2; e++) begin : g_lu_ex
        for (genvar s = 0; s < 4; s++) begin : g_lu_src
            hazard_cmp u_lu (
                .src_vld (src_vld[s]),
                .src_use (src_use[s]),
                .src_idx (src_idx[s]),
                .dst_en  (ex_mrd[e]),
                .dst_idx (ex_wr[e]),
                .hit     (lu_hit[e*4+s])
            );
        end
    end

    // Intra-pair RAW: slot1 sources against slot0's destination.
    for (genvar s = 0; s < 2; s++) begin : g_raw
        hazard_cmp u_raw (
            .src_vld (vld1),
            .src_use (src_use[2+s]),
            .src_idx (src_idx[2+s]),
            .dst_en  (we0 && vld0),
            .dst_idx (wr0),
            .hit     (raw_hit[s])
        );
    end

    assign lu0      = lu_hit[0] | lu_hit[1] | lu_hit[4] | lu_hit[5];
    assign lu1      = lu_hit[2] | lu_hit[3] | lu_hit[6] | lu_hit[7];
    assign waw      = we0 && we1 && (wr0 == wr1) && (wr0 != ZERO_REG);
    assign mem_conf = (mrd0 || mwr0) && (mrd1 || mwr1);
    assign pair     = vld0 && vld1 && ((|raw_hit) || waw || mem_conf);

    // Next-state and issue decision; reset forces all decision outputs low.
    always_comb begin
        state_nx   = state;
        bub_cnt_nx = bub_cnt;
        issue0     = 1'b0;
        issue1     = 1'b0;
        hold_ifid  = 1'b0;
        case (state)
            ISSUE: begin
                if (flush) begin
                    bub_cnt_nx = 2'd0;
                end else if (lu0 || lu1) begin
                    hold_ifid  = 1'b1;
                    bub_cnt_nx = BUB_INIT;
                    if (BUB_INIT != 2'd0) state_nx = LU_STALL;
                end else if (pair) begin
                    issue0    = 1'b1;
                    hold_ifid = 1'b1;
                    state_nx  = SPLIT;
                end else begin
                    issue0 = vld0;
                    issue1 = vld1;
                end
            end
            LU_STALL: begin
                if (flush) begin
                    bub_cnt_nx = 2'd0;
                    state_nx   = ISSUE;
                end else begin
                    hold_ifid  = 1'b1;
                    bub_cnt_nx = (bub_cnt == 2'd0) ? 2'd0 : bub_cnt - 2'd1;
                    if (bub_cnt <= 2'd1) state_nx = ISSUE;
                end
            end
            SPLIT: begin
                if (flush) begin
                    state_nx = ISSUE;
                end else if (lu1) begin
                    hold_ifid = 1'b1;
                end else begin
                    issue1   = vld1;
                    state_nx = ISSUE;
                end
            end
            default: begin
                state_nx   = ISSUE;
                bub_cnt_nx = 2'd0;
            end
        endcase
        if (rst) begin
            issue0    = 1'b0;
            issue1    = 1'b0;
            hold_ifid = 1'b0;
        end
    end

    assign has_stalled0 = issue0 && sticky0;
    assign has_stalled1 = issue1 && sticky1;

    // State register and load-use bubble counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ISSUE;
            bub_cnt <= 2'd0;
        end else begin
            state   <= state_nx;
            bub_cnt <= bub_cnt_nx;
        end
    end

    // Sticky "was held" flags per slot; slot0 in SPLIT is already gone, so its flag is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky0 <= 1'b0;
            sticky1 <= 1'b0;
        end else begin
            if (flush || issue0 || state == SPLIT) sticky0 <= 1'b0;
            else if (hold_ifid && vld0)           sticky0 <= 1'b1;
            if (flush || issue1)                   sticky1 <= 1'b0;
            else if (hold_ifid && vld1)           sticky1 <= 1'b1;
        end
    end

    // Saturating count of IF/ID hold cycles; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hold_ifid && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
